// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between the decoder and a simple
// req/ack data memory. Three-state FSM (IDLE -> BUSY -> RESP), store lane
// steering, load lane extraction and a BUSY-cycle timeout.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned H/W accesses
// instead of performing them with the low address bits ignored.
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // Counter compares against TIMEOUT-1 so the abort happens after exactly
    // TIMEOUT BUSY cycles; TIMEOUT=0 disables the compare entirely.
    localparam logic [31:0] TO_M1 = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      r_state, w_next;
    logic        r_is_load, r_err, r_mis, r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [3:0]  r_be;
    logic [31:0] r_addr, r_wdata, r_ld, r_cnt;

    logic        w_req, w_mis, w_timeout;
    logic        w_is_b, w_is_h;
    logic [3:0]  w_be_st;
    logic [31:0] w_wd_st, w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_req     = mem_read | mem_write;
    // funct3[1:0]: 00 byte, 01 half, 1x word (reserved codes fall into word)
    assign w_is_b    = (funct3[1:0] == 2'b00);
    assign w_is_h    = (funct3[1:0] == 2'b01);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_M1);

`ifdef MISALIGN_TRAP_EN
    assign w_mis = (w_is_h & addr[0]) | (funct3[1] & (addr[1:0] != 2'b00));
`else
    assign w_mis = 1'b0;
`endif

    // Store lane steering: byte enables and replicated write data
    always_comb begin
        w_be_st = 4'b1111;
        w_wd_st = wdata;
        if (w_is_b) begin
            w_be_st = 4'b0001 << addr[1:0];
            w_wd_st = {4{wdata[7:0]}};
        end else if (w_is_h) begin
            w_be_st = 4'b0011 << {addr[1], 1'b0};
            w_wd_st = {2{wdata[15:0]}};
        end
    end

    // Load lane extraction with sign/zero extension from the latched access
    always_comb begin
        case (r_off)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_f3[1:0])
            2'b00:   w_ext = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{~r_f3[2] & w_half[15]}}, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; ack beats the timeout in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_req) w_next = w_mis ? RESP : BUSY;
            BUSY: if (dmem_ack || w_timeout) w_next = RESP;
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request latch, timeout counter and load result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_load <= 1'b0;
            r_err     <= 1'b0;
            r_mis     <= 1'b0;
            r_we      <= 1'b0;
            r_f3      <= 3'd0;
            r_off     <= 2'd0;
            r_be      <= 4'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_ld      <= 32'd0;
            r_cnt     <= 32'd0;
        end else begin
            case (r_state)
                IDLE: if (w_req) begin
                    // a simultaneous read+write is treated as a store
                    r_is_load <= ~mem_write;
                    r_we      <= mem_write & ~w_mis;
                    r_be      <= mem_write ? w_be_st : 4'b1111;
                    r_wdata   <= w_wd_st;
                    r_addr    <= {addr[31:2], 2'b00};
                    r_off     <= addr[1:0];
                    r_f3      <= funct3;
                    r_err     <= 1'b0;
                    r_mis     <= w_mis;
                    r_cnt     <= 32'd0;
                end
                BUSY: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (dmem_ack) begin
                        if (r_is_load) r_ld <= w_ext;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        r_ld  <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state plus latched flags
    always_comb begin
        stall      = (r_state == BUSY) || ((r_state == IDLE) && w_req);
        dmem_req   = (r_state == BUSY);
        load_valid = (r_state == RESP) && r_is_load && !r_err && !r_mis;
        bus_err    = (r_state == RESP) && r_err;
`ifdef MISALIGN_TRAP_EN
        misalign   = (r_state == RESP) && r_mis;
`else
        misalign   = 1'b0;
`endif
    end

    assign dmem_we    = r_we;
    assign dmem_be    = r_be;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign load_data  = r_ld;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (TIMEOUT=4). Inputs change 1ns after the rising
// edge; outputs are sampled 1ns later, well away from the edge.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        stall, dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'd0, load_data;
    logic [3:0]  dmem_be;
    logic        load_valid, bus_err, misalign;
    int          checks = 0;
    int          errors = 0;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .load_data(load_data), .load_valid(load_valid),
        .bus_err(bus_err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Full load transaction, ack in cycle 2, result checked in cycle 3
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] exp);
        nxt(); mem_read = 1'b1; funct3 = f3; addr = a; #1;
        chk({tag, ".stall0"}, stall, 1);
        chk({tag, ".req0"}, dmem_req, 0);
        nxt(); mem_read = 1'b0; #1;
        chk({tag, ".req1"}, dmem_req, 1);
        chk({tag, ".addr"}, dmem_addr, a & 32'hFFFF_FFFC);
        chk({tag, ".be"}, dmem_be, 4'b1111);
        chk({tag, ".we"}, dmem_we, 0);
        nxt(); dmem_ack = 1'b1; dmem_rdata = rd; #1;
        chk({tag, ".stall2"}, stall, 1);
        nxt(); dmem_ack = 1'b0; dmem_rdata = 32'd0; #1;
        chk({tag, ".valid"}, load_valid, 1);
        chk({tag, ".data"}, load_data, exp);
        chk({tag, ".stall3"}, stall, 0);
        chk({tag, ".misalign"}, misalign, 0);
        nxt(); #1;
        chk({tag, ".valid_off"}, load_valid, 0);
        chk({tag, ".hold"}, load_data, exp);
    endtask

    // Full store transaction; load_data must keep its previous value
    task automatic run_store(input string tag, input logic both, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd,
                             input logic [31:0] exp_ld);
        nxt(); mem_write = 1'b1; mem_read = both; funct3 = f3; addr = a; wdata = wd; #1;
        chk({tag, ".stall0"}, stall, 1);
        nxt(); mem_write = 1'b0; mem_read = 1'b0; #1;
        chk({tag, ".req"}, dmem_req, 1);
        chk({tag, ".we"}, dmem_we, 1);
        chk({tag, ".be"}, dmem_be, exp_be);
        chk({tag, ".wdata"}, dmem_wdata, exp_wd);
        chk({tag, ".addr"}, dmem_addr, a & 32'hFFFF_FFFC);
        nxt(); dmem_ack = 1'b1; #1;
        nxt(); dmem_ack = 1'b0; #1;
        chk({tag, ".valid"}, load_valid, 0);
        chk({tag, ".stall3"}, stall, 0);
        chk({tag, ".ld_hold"}, load_data, exp_ld);
        nxt(); #1;
    endtask

    initial begin
        // reset
        nxt(); nxt(); #1;
        chk("rst.stall", stall, 0);
        chk("rst.req", dmem_req, 0);
        chk("rst.we", dmem_we, 0);
        chk("rst.be", dmem_be, 0);
        chk("rst.valid", load_valid, 0);
        chk("rst.err", bus_err, 0);
        chk("rst.mis", misalign, 0);
        chk("rst.ld", load_data, 0);
        rst_n = 1'b1;

        run_load("lw",  3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        run_load("lb",  3'b000, 32'h103, 32'h80123456, 32'hFFFFFF80);
        run_load("lbu", 3'b100, 32'h103, 32'h80123456, 32'h00000080);
        run_load("lhu", 3'b101, 32'h102, 32'hBEEF0000, 32'h0000BEEF);
        run_load("lh",  3'b001, 32'h100, 32'h12348001, 32'hFFFF8001);
        run_load("lb1", 3'b000, 32'h101, 32'h0000_7F00, 32'h0000007F);

        run_store("sb", 1'b0, 3'b000, 32'h201, 32'h12345678, 4'b0010, 32'h78787878, 32'h0000007F);
        run_store("sh", 1'b0, 3'b001, 32'h202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 32'h0000007F);
        run_store("sw_rsv", 1'b0, 3'b011, 32'h300, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h0000007F);
        run_store("rw_both", 1'b1, 3'b010, 32'h040, 32'h0BADC0DE, 4'b1111, 32'h0BADC0DE, 32'h0000007F);

        // ack while idle must be ignored
        nxt(); dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF; #1;
        nxt(); dmem_ack = 1'b0; #1;
        chk("idle_ack.valid", load_valid, 0);
        chk("idle_ack.ld", load_data, 32'h0000007F);

        // timeout: no ack ever
        nxt(); mem_read = 1'b1; funct3 = 3'b010; addr = 32'h10; #1;
        for (int i = 0; i < 4; i++) begin
            nxt(); mem_read = 1'b0; #1;
            chk("to.req", dmem_req, 1);
            chk("to.err_early", bus_err, 0);
        end
        nxt(); #1;
        chk("to.req_drop", dmem_req, 0);
        chk("to.err", bus_err, 1);
        chk("to.stall", stall, 0);
        chk("to.valid", load_valid, 0);
        chk("to.ld", load_data, 0);
        nxt(); #1;
        chk("to.err_off", bus_err, 0);

        // ack on the 4th BUSY cycle beats the timeout
        nxt(); mem_read = 1'b1; funct3 = 3'b010; addr = 32'h14; #1;
        for (int i = 0; i < 3; i++) begin
            nxt(); mem_read = 1'b0; #1;
        end
        nxt(); dmem_ack = 1'b1; dmem_rdata = 32'h11223344; #1;
        chk("to_ack.req", dmem_req, 1);
        nxt(); dmem_ack = 1'b0; #1;
        chk("to_ack.err", bus_err, 0);
        chk("to_ack.valid", load_valid, 1);
        chk("to_ack.ld", load_data, 32'h11223344);
        nxt(); #1;

        // reset in the 2nd BUSY cycle, late ack afterwards
        nxt(); mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100; #1;
        nxt(); mem_read = 1'b0; #1;
        nxt(); rst_n = 1'b0; #1;
        chk("rbusy.req_before", dmem_req, 1);
        nxt(); rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h55555555; #1;
        chk("rbusy.req", dmem_req, 0);
        chk("rbusy.valid", load_valid, 0);
        chk("rbusy.ld", load_data, 0);
        nxt(); dmem_ack = 1'b0; #1;
        chk("rbusy.valid2", load_valid, 0);
        chk("rbusy.err", bus_err, 0);
        run_load("lw_after_rst", 3'b010, 32'h100, 32'hA5A5_5A5A, 32'hA5A5_5A5A);

        // misaligned word load at 0x102
`ifdef MISALIGN_TRAP_EN
        nxt(); mem_read = 1'b1; funct3 = 3'b010; addr = 32'h102; #1;
        chk("mis.stall0", stall, 1);
        nxt(); mem_read = 1'b0; #1;
        chk("mis.req", dmem_req, 0);
        chk("mis.flag", misalign, 1);
        chk("mis.valid", load_valid, 0);
        chk("mis.stall1", stall, 0);
        nxt(); #1;
        chk("mis.flag_off", misalign, 0);
        chk("mis.req2", dmem_req, 0);
`else
        run_load("lw_mis", 3'b010, 32'h102, 32'hFEDC_BA98, 32'hFEDC_BA98);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
